seven_segment_display_capture: RTL

SEVEN_SEGMENT_DISPLAY_CAPTURE -- requirements
Module: seven_segment_display_capture

---
 rtl/seven_segment_pkg.sv | 22 ++
 rtl/seven_segment_display_capture_decoder.sv | 34 +++
 rtl/seven_segment_display_capture.sv | 103 ++++++++++
 3 files changed

// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: segment pattern constants, capture state type and default settle length.
package seven_segment_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;
  localparam int SETTLE_CYCLES_DEFAULT = 4;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/seven_segment_display_capture_decoder.sv
// seven_segment_pattern_decoder: active-low {g..a} pattern to nibble; A-F only with SEG_HEX_DECODE_EN.
module seven_segment_pattern_decoder
  import seven_segment_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       valid
);
  always_comb begin
    value = 4'h0;
    valid = 1'b1;
    case (pattern)
      SEG_0: value = 4'h0;
      SEG_1: value = 4'h1;
      SEG_2: value = 4'h2;
      SEG_3: value = 4'h3;
      SEG_4: value = 4'h4;
      SEG_5: value = 4'h5;
      SEG_6: value = 4'h6;
      SEG_7: value = 4'h7;
      SEG_8: value = 4'h8;
      SEG_9: value = 4'h9;
`ifdef SEG_HEX_DECODE_EN
      SEG_A: value = 4'hA;
      SEG_B: value = 4'hB;
      SEG_C: value = 4'hC;
      SEG_D: value = 4'hD;
      SEG_E: value = 4'hE;
      SEG_F: value = 4'hF;
`endif
      default: valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/seven_segment_display_capture.sv
// seven_segment_display_capture: samples a multiplexed 4-digit display into a frame.
// Hex digits A-F decode only when SEG_HEX_DECODE_EN is defined.
module seven_segment_display_capture
  import seven_segment_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CA,
  input  logic        CB,
  input  logic        CC,
  input  logic        CD,
  input  logic        CE,
  input  logic        CF,
  input  logic        CG,
  input  logic        DP,
  input  logic        AN1,
  input  logic        AN2,
  input  logic        AN3,
  input  logic        AN4,
  output logic [15:0] digits_out,
  output logic [3:0]  dp_out,
  output logic        frame_valid,
  output logic        seg_error
);
  logic [3:0] an_r, an_p, mask, dp_shadow;
  logic [7:0] pat_r, pat_p, cnt, cnt_n;
  logic [15:0] shadow;
  logic [3:0] nib;
  logic dec_ok, held, held_n, blank, onehot, conflict, an_chg, sampling, sample_ok;
  state_t state, state_n;
  seven_segment_pattern_decoder u_dec (.pattern(pat_r[6:0]), .value(nib), .valid(dec_ok));
  assign blank = &an_r;
  assign onehot = $onehot(~an_r);
  assign conflict = !blank && !onehot;
  assign an_chg = an_r != an_p;
  assign sampling = state == SAMPLE && onehot && !an_chg;
  assign sample_ok = sampling && dec_ok;
  // held blocks re-sampling a steady digit until the anode vector moves
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    held_n = held;
    if (blank || conflict) begin
      state_n = IDLE;
      cnt_n = 8'd0;
      held_n = 1'b0;
    end else if (an_chg) begin
      state_n = SETTLE;
      cnt_n = 8'd0;
      held_n = 1'b0;
    end else if (state == IDLE) begin
      state_n = held ? IDLE : SETTLE;
      cnt_n = 8'd0;
    end else if (state == SETTLE) begin
      if (pat_r != pat_p) cnt_n = 8'd0;
      else if (cnt == 8'(SETTLE_CYCLES - 1)) state_n = SAMPLE;
      else cnt_n = cnt + 8'd1;
    end else begin
      state_n = IDLE;
      held_n = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      an_r <= 4'hF;
      an_p <= 4'hF;
      pat_r <= 8'hFF;
      pat_p <= 8'hFF;
      state <= IDLE;
      cnt <= 8'd0;
      held <= 1'b0;
      mask <= 4'h0;
      shadow <= 16'h0000;
      dp_shadow <= 4'h0;
      digits_out <= 16'h0000;
      dp_out <= 4'h0;
      frame_valid <= 1'b0;
      seg_error <= 1'b0;
    end else begin
      an_r <= {AN4, AN3, AN2, AN1};
      an_p <= an_r;
      pat_r <= {DP, CG, CF, CE, CD, CC, CB, CA};
      pat_p <= pat_r;
      state <= state_n;
      cnt <= cnt_n;
      held <= held_n;
      seg_error <= conflict || (sampling && !dec_ok);
      frame_valid <= &mask;
      if (&mask) begin
        digits_out <= shadow;
        dp_out <= dp_shadow;
      end
      mask <= conflict ? 4'h0 : ((&mask ? 4'h0 : mask) | (sample_ok ? ~an_r : 4'h0));
      for (int i = 0; i < 4; i++)
        if (sample_ok && !an_r[i]) begin
          shadow[4*i +: 4] <= nib;
          dp_shadow[i] <= ~pat_r[7];
        end
    end
  end
endmodule
